// File: rtl/rank_pipe_pkg.sv
// Shared rank-pipe definitions: descriptor widths, table sizing and the
// descriptor record exchanged between the front end and the rank blocks.
package rank_pipe_pkg;

    localparam int FLOW_ID_WIDTH       = 16;
    localparam int FLOW_WEIGHT_WIDTH   = 8;
    localparam int META_WIDTH          = 16;
    localparam int RANK_WIDTH          = 32;
    localparam int MAX_NUM_FLOWS       = 4;
    localparam int DEFAULT_FLOW_WEIGHT = 1;

    typedef struct packed {
        logic [FLOW_ID_WIDTH-1:0]     flow_id;
        logic [FLOW_WEIGHT_WIDTH-1:0] weight;
        logic [META_WIDTH-1:0]        meta;
    } rank_desc_t;

endpackage

// File: rtl/rank_pipe_arbiter_rr.sv
// Round-robin arbiter: searches upward from the last granted index and only
// moves its pointer when the caller reports a completed handshake.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 adv,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found_s;
    logic [IW-1:0] idx_s;

    // Priority search: indices above the pointer first, then wrap to the rest
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        for (int p = 0; p < N; p++) begin
            if (!found_s && req[p] && (IW'(p) > ptr_q)) begin
                found_s = 1'b1;
                idx_s   = IW'(p);
            end else begin
                idx_s   = idx_s;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (!found_s && req[p] && (IW'(p) <= ptr_q)) begin
                found_s = 1'b1;
                idx_s   = IW'(p);
            end else begin
                idx_s   = idx_s;
            end
        end
    end

    // Grant outputs and pointer next state
    always_comb begin
        valid = found_s;
        idx   = idx_s;
        grant = found_s ? (N'(1) << idx_s) : '0;
        if (adv) begin
            ptr_d = idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset so that index 0 wins first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rank_pipe_arbiter.sv
// Ingress front end of the rank pipe: round-robin scheduling of requester
// descriptors, flow-weight lookup, out-of-range filtering and one output stage.
module rank_pipe_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int FLOW_ID_WIDTH     = rank_pipe_pkg::FLOW_ID_WIDTH,
    parameter int FLOW_WEIGHT_WIDTH = rank_pipe_pkg::FLOW_WEIGHT_WIDTH,
    parameter int MAX_NUM_FLOWS     = rank_pipe_pkg::MAX_NUM_FLOWS,
    parameter int META_WIDTH        = rank_pipe_pkg::META_WIDTH,
    parameter int DROP_CNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                req_ready,
    input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0]  req_flow_id,
    input  logic [NUM_PORTS*META_WIDTH-1:0]     req_meta,
    input  logic                                cfg_wr_en,
    input  logic [FLOW_ID_WIDTH-1:0]            cfg_flow_id,
    input  logic [FLOW_WEIGHT_WIDTH-1:0]        cfg_weight,
    input  logic                                rank_accept,
    output logic                                rank_insert,
    output logic [FLOW_ID_WIDTH-1:0]            rank_flow_id,
    output logic [FLOW_WEIGHT_WIDTH-1:0]        rank_weight,
    output logic [META_WIDTH-1:0]               rank_meta,
    output logic [$clog2(NUM_PORTS)-1:0]        grant_port,
    output logic [DROP_CNT_WIDTH-1:0]           drop_cnt
);

    import rank_pipe_pkg::*;

    localparam int GW = $clog2(NUM_PORTS);
    localparam int TW = $clog2(MAX_NUM_FLOWS);
    localparam logic [FLOW_ID_WIDTH-1:0]     FLOW_LIMIT = FLOW_ID_WIDTH'(MAX_NUM_FLOWS);
    localparam logic [FLOW_WEIGHT_WIDTH-1:0] WEIGHT_RST = FLOW_WEIGHT_WIDTH'(DEFAULT_FLOW_WEIGHT);

    logic                          out_vld_q,  out_vld_d;
    logic [FLOW_ID_WIDTH-1:0]      flow_q,     flow_d;
    logic [FLOW_WEIGHT_WIDTH-1:0]  weight_q,   weight_d;
    logic [META_WIDTH-1:0]         meta_q,     meta_d;
    logic [GW-1:0]                 port_q,     port_d;
    logic [DROP_CNT_WIDTH-1:0]     drop_q,     drop_d;
    logic [FLOW_WEIGHT_WIDTH-1:0]  wtbl_q [MAX_NUM_FLOWS];
    logic [FLOW_WEIGHT_WIDTH-1:0]  wtbl_d [MAX_NUM_FLOWS];

    logic                          stage_free_s;
    logic                          hs_s;
    logic                          in_range_s;
    logic                          any_s;
    logic [NUM_PORTS-1:0]          grant_s;
    logic [GW-1:0]                 gidx_s;
    logic [FLOW_ID_WIDTH-1:0]      sel_flow_s;
    logic [META_WIDTH-1:0]         sel_meta_s;
    logic                          wr_hit_s;
    logic [FLOW_WEIGHT_WIDTH-1:0]  wr_val_s;

    rr_arbiter #(
        .N     (NUM_PORTS)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .adv   (hs_s),
        .grant (grant_s),
        .idx   (gidx_s),
        .valid (any_s)
    );

    // Handshake qualification; ready is forced low while reset is asserted
    always_comb begin
        stage_free_s = ~out_vld_q | rank_accept;
        hs_s         = any_s & stage_free_s & rst_n;
        req_ready    = grant_s & {NUM_PORTS{stage_free_s & rst_n}};
        rank_insert  = out_vld_q & rank_accept;
    end

    // One-hot mux of the winning descriptor fields
    always_comb begin
        sel_flow_s = '0;
        sel_meta_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_flow_s = sel_flow_s | (req_flow_id[p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH] & {FLOW_ID_WIDTH{grant_s[p]}});
            sel_meta_s = sel_meta_s | (req_meta[p*META_WIDTH +: META_WIDTH] & {META_WIDTH{grant_s[p]}});
        end
        in_range_s = (sel_flow_s < FLOW_LIMIT);
        wr_hit_s   = cfg_wr_en & (cfg_flow_id < FLOW_LIMIT);
        wr_val_s   = (cfg_weight == '0) ? WEIGHT_RST : cfg_weight;
    end

    // Output stage, drop counter and weight table next state.
    // The stage reads wtbl_q, so a same-cycle write is seen only by later grants.
    always_comb begin
        out_vld_d = out_vld_q;
        flow_d    = flow_q;
        weight_d  = weight_q;
        meta_d    = meta_q;
        port_d    = port_q;
        drop_d    = drop_q;
        wtbl_d    = wtbl_q;
        if (hs_s && in_range_s) begin
            out_vld_d = 1'b1;
            flow_d    = sel_flow_s;
            weight_d  = wtbl_q[sel_flow_s[TW-1:0]];
            meta_d    = sel_meta_s;
            port_d    = gidx_s;
        end else if (rank_insert) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
        if (hs_s && !in_range_s && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end else begin
            drop_d = drop_q;
        end
        if (wr_hit_s) begin
            wtbl_d[cfg_flow_id[TW-1:0]] = wr_val_s;
        end else begin
            wtbl_d = wtbl_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            flow_q    <= '0;
            weight_q  <= '0;
            meta_q    <= '0;
            port_q    <= '0;
            drop_q    <= '0;
            for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
                wtbl_q[i] <= WEIGHT_RST;
            end
        end else begin
            out_vld_q <= out_vld_d;
            flow_q    <= flow_d;
            weight_q  <= weight_d;
            meta_q    <= meta_d;
            port_q    <= port_d;
            drop_q    <= drop_d;
            wtbl_q    <= wtbl_d;
        end
    end

    // Registered outputs toward the rank block
    always_comb begin
        rank_flow_id = flow_q;
        rank_weight  = weight_q;
        rank_meta    = meta_q;
        grant_port   = port_q;
        drop_cnt     = drop_q;
    end

endmodule
